icache: RTL and testbench
=========================

# icache

Direct-mapped, blocking instruction cache; the responder end of the Fetch1/Fetch2 cache port driven by the CPU top. A request (idx, op, pa, is_cached) is accepted in the Fetch1 cycle. The result (ready, data) is returned in the Fetch2 cycle on a hit, or later after a line refill over a simple burst read port to the memory bus.

## Interface
- INDEX_BITS, 8, line index width; 2^INDEX_BITS lines.
- LINE_WORDS, 4, 32-bit words per line; offset = log2(LINE_WORDS*4) bits. INDEX_BITS + offset bits = 12.
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- is_stall  in  1  CPU Fetch2 stall; while high, no new request is accepted and the response is held.
- idx  in  12  virtual index: idx[11:offset] selects the line, idx[offset-1:2] selects the word.
- op  in  3  0 NOP, 1 FETCH, 2 IDX_INV (invalidate line at idx), 3 HIT_INV (invalidate line if its tag equals pa[31:12]). Others are treated as NOP.
- is_cached  in  1  1 = cacheable FETCH; 0 = uncached single-word read.
- pa  in  32  physical address; tag = pa[31:12].
- ready  out  1  response valid in Fetch2.
- data  out  32  instruction word; 0 when the accepted op is not FETCH.
- rd_req  out  1  memory read request.
- rd_type  out  1  1 = line burst, 0 = single word.
- rd_addr  out  32  line-aligned pa for a burst; pa for a single word.
- rd_rdy  in  1  memory accepts rd_req this cycle.
- ret_valid  in  1  return beat valid.
- ret_last  in  1  last return beat.
- ret_data  in  32  return beat data, in ascending word order.

## Operation
- Storage:
  - Valid bits are flops, cleared by reset.
  - Tag and data arrays are synchronous-read RAMs addressed by idx in the accept cycle.
- Accept: a request is accepted when state = LOOKUP and (!is_stall or no request is pending). On accept, idx/op/pa/is_cached are registered into the response stage (s1). A NOP leaves s1 invalid.
- States: LOOKUP, MISS, REFILL, DONE.
- LOOKUP with a valid s1:
  - FETCH, cached, hit (valid & tag match): ready=1, data = RAM word. Stay in LOOKUP.
  - FETCH, cached miss or uncached: ready=0, go to MISS.
  - IDX_INV: clear valid[index], ready=1, data=0.
  - HIT_INV: clear valid[index] only on tag match; ready=1, data=0.
- MISS: hold rd_req=1 with stable rd_type/rd_addr until rd_rdy, then go to REFILL.
- REFILL:
  - Each ret_valid beat is counted by a beat counter (wraps at LINE_WORDS). For a cached request the beat is written to data RAM[index][count].
  - The beat whose count equals pa word offset is captured as the response word; an uncached request captures beat 0.
  - On ret_last, a cached request writes the tag and sets valid. Then go to DONE.
- DONE: ready=1, data = captured word. Held while is_stall=1. On !is_stall the next request is accepted and the state returns to LOOKUP.
- No request is accepted in MISS or REFILL, whatever the value of is_stall.
- Lookup of a line written in REFILL, accepted from DONE, sees the new contents.
- A hit whose response is held by is_stall keeps ready=1 and data stable; the response is registered on first presentation.

## Timing
- Reset (asynchronous, immediate) sets:
  - state=LOOKUP, s1 invalid, all valid bits clear;
  - ready=0, data=0, rd_req=0, rd_type=0, rd_addr=0, beat counter 0.
- Hit latency: request accepted at edge T, ready=1 during cycle T+1.
- Miss:
  - Lookup in cycle T+1 shows ready=0.
  - rd_req is asserted from cycle T+2 until rd_rdy.
  - ready=1 in the cycle after the ret_last beat.
- Invalidate ops: ready=1 in T+1; the valid bit is cleared at the end of T+1.
- A ret_valid beat arriving in the same cycle as rd_rdy is ignored. Memory returns data only after the handshake.
- Reset mid-refill aborts: rd_req is dropped, and the partial line stays invalid (its valid bit is clear).

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> ready=0, data=0, rd_req=0. Release it, then FETCH pa=0x1C000000 cached -> miss.
- Cold miss, cached:
  - Stimulus: FETCH idx=pa=0x1C000008; rd_rdy after 2 cycles; beats 0xA0..0xA3 with ret_last on the 4th.
  - Required: rd_addr=0x1C000000, rd_type=1, ready=1 with data=0xA2 one cycle after the last beat.
  - Then FETCH pa=0x1C00000C -> hit, ready in T+1, data=0xA3, no rd_req.
- Uncached:
  - Stimulus: FETCH pa=0x1FE00004, is_cached=0; one beat 0x12345678 with ret_last.
  - Required: rd_type=0, rd_addr=0x1FE00004, data=0x12345678.
  - A repeat request misses again (the line was never allocated).
- Invalidate:
  - After line 0x1C000000 is filled, HIT_INV with pa=0x1D000000 -> ready=1, data=0, line still hits.
  - HIT_INV with pa=0x1C000000 -> next FETCH misses.
  - IDX_INV idx=0x000 behaves the same way with no tag check.
- Stall hold: hit response with is_stall=1 for 4 cycles -> ready and data constant, and idx/pa changes are ignored. Deassert is_stall -> the new request is accepted and answered next cycle.
- Conflict: FETCH 0x1C000010 then 0x1D000010 (same index) -> the second misses and refills. A third FETCH of 0x1C000010 misses again.

Source files
------------

// File: rtl/icache.sv
`default_nettype none
//==============================================================================
// Module   : icache
// Brief    : Direct-mapped blocking instruction cache. Accepts a request in
//            Fetch1, answers in Fetch2 on a hit, otherwise refills the line
//            (or reads a single uncached word) over a burst read port.
// Revision : 1.0 - initial release
//==============================================================================
module icache #(
    parameter int INDEX_BITS = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_stall,
    input  logic [11:0] idx,
    input  logic [2:0]  op,
    input  logic        is_cached,
    input  logic [31:0] pa,
    output logic        ready,
    output logic [31:0] data,
    output logic        rd_req,
    output logic        rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
);

    localparam int c_OFFSET_BITS = $clog2(LINE_WORDS * 4);
    localparam int c_WORD_BITS   = $clog2(LINE_WORDS);
    localparam int c_TAG_LSB     = INDEX_BITS + c_OFFSET_BITS;
    localparam int c_TAG_BITS    = 32 - c_TAG_LSB;
    localparam int c_NUM_LINES   = 1 << INDEX_BITS;
    localparam int c_RAM_DEPTH   = c_NUM_LINES * LINE_WORDS;

    localparam logic [2:0] c_OP_FETCH   = 3'd1;
    localparam logic [2:0] c_OP_IDX_INV = 3'd2;
    localparam logic [2:0] c_OP_HIT_INV = 3'd3;

    localparam logic [1:0] c_ST_LOOKUP = 2'd0;
    localparam logic [1:0] c_ST_MISS   = 2'd1;
    localparam logic [1:0] c_ST_REFILL = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    // Controller state
    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;

    // Response-stage (s1) copy of the accepted request
    logic                       r_s1_valid;
    logic [2:0]                 r_s1_op;
    logic [INDEX_BITS-1:0]      r_s1_index;
    logic [31:0]                r_s1_pa;
    logic                       r_s1_cached;

    // Storage
    logic [c_NUM_LINES-1:0]     r_valid;
    logic [c_TAG_BITS-1:0]      r_tag_ram [c_NUM_LINES];
    logic [31:0]                r_data_ram [c_RAM_DEPTH];
    logic [c_TAG_BITS-1:0]      r_tag_q;
    logic [31:0]                r_data_q;

    // Refill bookkeeping
    logic [c_WORD_BITS-1:0]     r_beat;
    logic [31:0]                r_capture;

    // Decoded helpers
    logic [INDEX_BITS-1:0]      w_rd_index;
    logic [c_WORD_BITS-1:0]     w_rd_word;
    logic [c_WORD_BITS-1:0]     w_s1_word;
    logic                       w_is_fetch;
    logic                       w_tag_match;
    logic                       w_hit;
    logic                       w_miss;
    logic                       w_accept;
    logic                       w_op_valid;
    logic                       w_beat_take;
    logic                       w_beat_wr;
    logic                       w_capture_sel;
    logic                       w_fill_done;
    logic                       w_clr_valid;
    logic                       w_unused_idx;

    assign w_rd_index   = idx[c_OFFSET_BITS +: INDEX_BITS];
    assign w_rd_word    = idx[2 +: c_WORD_BITS];
    assign w_s1_word    = r_s1_pa[2 +: c_WORD_BITS];
    assign w_unused_idx = &{1'b0, idx[1:0]};

    // Hit/miss classification of the request sitting in s1
    always_comb begin
        w_is_fetch  = r_s1_valid && (r_s1_op == c_OP_FETCH);
        w_tag_match = (r_tag_q == r_s1_pa[31:c_TAG_LSB]);
        w_hit       = r_valid[r_s1_index] && w_tag_match;
        w_miss      = w_is_fetch && (!r_s1_cached || !w_hit);
        w_op_valid  = (op == c_OP_FETCH) || (op == c_OP_IDX_INV) || (op == c_OP_HIT_INV);
    end

    // Refill beat handling: beats are only honoured after the handshake
    always_comb begin
        w_beat_take   = (r_state == c_ST_REFILL) && ret_valid;
        w_beat_wr     = w_beat_take && r_s1_cached;
        w_capture_sel = r_s1_cached ? (r_beat == w_s1_word) : (r_beat == '0);
        w_fill_done   = w_beat_wr && ret_last;
        w_clr_valid   = (r_state == c_ST_LOOKUP) && r_s1_valid &&
                        ((r_s1_op == c_OP_IDX_INV) ||
                         ((r_s1_op == c_OP_HIT_INV) && w_tag_match));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_LOOKUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, accept and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        ready       = 1'b0;
        data        = 32'd0;
        rd_req      = 1'b0;
        rd_type     = 1'b0;
        rd_addr     = 32'd0;
        case (r_state)
            c_ST_LOOKUP: begin
                if (!r_s1_valid) begin
                    w_accept = 1'b1;
                end else if (w_miss) begin
                    w_state_nxt = c_ST_MISS;
                end else begin
                    ready    = 1'b1;
                    data     = w_is_fetch ? r_data_q : 32'd0;
                    w_accept = !is_stall;
                end
            end
            c_ST_MISS: begin
                rd_req  = 1'b1;
                rd_type = r_s1_cached;
                rd_addr = r_s1_cached ? {r_s1_pa[31:c_OFFSET_BITS], {c_OFFSET_BITS{1'b0}}}
                                      : r_s1_pa;
                if (rd_rdy) begin
                    w_state_nxt = c_ST_REFILL;
                end
            end
            c_ST_REFILL: begin
                if (ret_valid && ret_last) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                ready = 1'b1;
                data  = r_capture;
                if (!is_stall) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_ST_LOOKUP;
                end
            end
            default: begin
                w_state_nxt = c_ST_LOOKUP;
            end
        endcase
    end

    // Capture the accepted request into s1; NOP and unknown ops leave it empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= 3'd0;
            r_s1_index  <= '0;
            r_s1_pa     <= 32'd0;
            r_s1_cached <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid  <= w_op_valid;
            r_s1_op     <= op;
            r_s1_index  <= w_rd_index;
            r_s1_pa     <= pa;
            r_s1_cached <= is_cached;
        end
    end

    // Valid bits: set when a cached refill completes, cleared by invalidates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_fill_done) begin
            r_valid[r_s1_index] <= 1'b1;
        end else if (w_clr_valid) begin
            r_valid[r_s1_index] <= 1'b0;
        end
    end

    // Tag RAM: synchronous read on accept, written when the line completes
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag_q <= r_tag_ram[w_rd_index];
        end
        if (w_fill_done) begin
            r_tag_ram[r_s1_index] <= r_s1_pa[31:c_TAG_LSB];
        end
    end

    // Data RAM: synchronous read on accept, one word written per refill beat
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data_q <= r_data_ram[{w_rd_index, w_rd_word}];
        end
        if (w_beat_wr) begin
            r_data_ram[{r_s1_index, r_beat}] <= ret_data;
        end
    end

    // Beat counter and response-word capture during refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat    <= '0;
            r_capture <= 32'd0;
        end else if (w_beat_take) begin
            r_beat <= ret_last ? '0 : r_beat + 1'b1;
            if (w_capture_sel) begin
                r_capture <= ret_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
//==============================================================================
// Module   : tb_icache
// Brief    : Directed scoreboard bench for icache with a burst memory model
// Revision : 1.0 - initial release
//==============================================================================
module tb_icache;

    localparam logic [2:0] c_OP_NOP     = 3'd0;
    localparam logic [2:0] c_OP_FETCH   = 3'd1;
    localparam logic [2:0] c_OP_IDX_INV = 3'd2;
    localparam logic [2:0] c_OP_HIT_INV = 3'd3;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        is_stall  = 1'b0;
    logic [11:0] idx       = 12'd0;
    logic [2:0]  op        = 3'd0;
    logic        is_cached = 1'b0;
    logic [31:0] pa        = 32'd0;
    logic        ready;
    logic [31:0] data;
    logic        rd_req;
    logic        rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy    = 1'b0;
    logic        ret_valid = 1'b0;
    logic        ret_last  = 1'b0;
    logic [31:0] ret_data  = 32'd0;

    icache dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .is_stall  (is_stall),
        .idx       (idx),
        .op        (op),
        .is_cached (is_cached),
        .pa        (pa),
        .ready     (ready),
        .data      (data),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] data;
        int          issue;
        bit          chk_lat;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        typ;
    } rdx_t;

    rsp_t sb[$];
    rdx_t rdq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents seen by the refill port
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h1C00000) return 32'hA0 + {28'd0, a[3:2], 2'b00} / 4;
        if (a == 32'h1FE00004)      return 32'h12345678;
        return a ^ 32'hDEAD0000;
    endfunction

    // Response monitor: held responses are compared, consumed ones are popped
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", {31'd0, ready}, 32'd0);
                end else begin
                    e = sb[0];
                    if (is_stall) begin
                        chk("held_data", data, e.data);
                    end else begin
                        chk("rsp_data", data, e.data);
                        e = sb.pop_front();
                        if (e.chk_lat) chk("hit_latency", cyc - e.issue, 32'd1);
                    end
                end
            end
        end
    end

    // Memory responder: checks the read request, then returns beats
    initial begin
        rdx_t        r;
        int          nb;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (rst_n && rd_req) begin
                if (rdq.size() == 0) begin
                    chk("unexpected_rd_req", {31'd0, rd_req}, 32'd0);
                end else begin
                    r = rdq.pop_front();
                    chk("rd_addr", rd_addr, r.addr);
                    chk("rd_type", {31'd0, rd_type}, {31'd0, r.typ});
                    repeat (2) begin
                        @(negedge clk);
                        chk("rd_req_hold", {31'd0, rd_req}, 32'd1);
                        chk("rd_addr_hold", rd_addr, r.addr);
                    end
                    // A bogus beat during the handshake cycle must be ignored
                    rd_rdy    = 1'b1;
                    ret_valid = 1'b1;
                    ret_last  = 1'b1;
                    ret_data  = 32'hBAD0BAD0;
                    @(negedge clk);
                    rd_rdy    = 1'b0;
                    ret_valid = 1'b0;
                    ret_last  = 1'b0;
                    chk("rd_req_drop", {31'd0, rd_req}, 32'd0);
                    nb = r.typ ? 4 : 1;
                    for (int i = 0; i < nb; i++) begin
                        a         = r.typ ? (r.addr + 32'(4 * i)) : r.addr;
                        ret_valid = 1'b1;
                        ret_data  = mem_word(a);
                        ret_last  = (i == nb - 1);
                        @(negedge clk);
                        if (!rst_n) break;
                    end
                    ret_valid = 1'b0;
                    ret_last  = 1'b0;
                    ret_data  = 32'd0;
                end
            end
        end
    end

    task automatic expect_rd(input logic [31:0] a, input logic t);
        rdx_t r;
        r.addr = a;
        r.typ  = t;
        rdq.push_back(r);
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] p, input logic c,
                         input logic [31:0] d, input bit lat);
        rsp_t e;
        op        = o;
        pa        = p;
        idx       = p[11:0];
        is_cached = c;
        e.data    = d;
        e.issue   = cyc;
        e.chk_lat = lat;
        sb.push_back(e);
    endtask

    task automatic idle_wait();
        int t;
        t = 0;
        @(negedge clk);
        op = c_OP_NOP;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic req(input logic [2:0] o, input logic [31:0] p, input logic c,
                       input logic [31:0] d, input bit lat);
        drive(o, p, c, d, lat);
        idle_wait();
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int t;
        // Reset with a live request on the inputs
        op = c_OP_FETCH; pa = 32'h1C000000; idx = 12'h000; is_cached = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready",   {31'd0, ready},   32'd0);
        chk("reset_data",    data,             32'd0);
        chk("reset_rd_req",  {31'd0, rd_req},  32'd0);
        chk("reset_rd_type", {31'd0, rd_type}, 32'd0);
        chk("reset_rd_addr", rd_addr,          32'd0);
        rst_n = 1'b1;
        op    = c_OP_NOP;
        @(negedge clk);

        // First fetch misses; reset lands in the middle of its refill
        expect_rd(32'h1C000000, 1'b1);
        op = c_OP_FETCH; pa = 32'h1C000000; idx = 12'h000; is_cached = 1'b1;
        @(negedge clk);
        op = c_OP_NOP;
        t  = 0;
        do begin
            @(negedge clk);
            #2;
            t++;
        end while (!(ret_valid && !rd_rdy) && t < 200);
        rst_n = 1'b0;
        #1;
        chk("abort_rd_req", {31'd0, rd_req}, 32'd0);
        chk("abort_ready",  {31'd0, ready},  32'd0);
        chk("abort_data",   data,            32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss (partial line stayed invalid), then a hit issued from DONE
        expect_rd(32'h1C000000, 1'b1);
        drive(c_OP_FETCH, 32'h1C000008, 1'b1, 32'hA2, 1'b0);
        @(negedge clk);
        op = c_OP_NOP;
        wait_ready();
        drive(c_OP_FETCH, 32'h1C00000C, 1'b1, 32'hA3, 1'b1);
        idle_wait();

        // Uncached word read, twice: never allocated
        expect_rd(32'h1FE00004, 1'b0);
        req(c_OP_FETCH, 32'h1FE00004, 1'b0, 32'h12345678, 1'b0);
        expect_rd(32'h1FE00004, 1'b0);
        req(c_OP_FETCH, 32'h1FE00004, 1'b0, 32'h12345678, 1'b0);
        req(c_OP_FETCH, 32'h1C000000, 1'b1, 32'hA0, 1'b1);

        // HIT_INV with a foreign tag leaves the line in place
        req(c_OP_HIT_INV, 32'h1D000000, 1'b1, 32'd0, 1'b1);
        req(c_OP_FETCH,   32'h1C000004, 1'b1, 32'hA1, 1'b1);

        // HIT_INV with the matching tag drops the line
        req(c_OP_HIT_INV, 32'h1C000000, 1'b1, 32'd0, 1'b1);
        expect_rd(32'h1C000000, 1'b1);
        req(c_OP_FETCH,   32'h1C000004, 1'b1, 32'hA1, 1'b0);

        // IDX_INV drops the line without a tag check
        req(c_OP_IDX_INV, 32'h12345000, 1'b1, 32'd0, 1'b1);
        expect_rd(32'h1C000000, 1'b1);
        req(c_OP_FETCH,   32'h1C000000, 1'b1, 32'hA0, 1'b0);

        // Stall hold: response frozen while other requests wave at the port
        drive(c_OP_FETCH, 32'h1C00000C, 1'b1, 32'hA3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            is_stall = 1'b1;
            op       = c_OP_FETCH;
            pa       = 32'h1C000000 + 32'(4 * i);
            idx      = pa[11:0];
        end
        @(negedge clk);
        is_stall = 1'b0;
        drive(c_OP_FETCH, 32'h1C000004, 1'b1, 32'hA1, 1'b1);
        idle_wait();

        // Conflict on the same index
        expect_rd(32'h1C000010, 1'b1);
        req(c_OP_FETCH, 32'h1C000010, 1'b1, 32'hC2AD0010, 1'b0);
        expect_rd(32'h1D000010, 1'b1);
        req(c_OP_FETCH, 32'h1D000010, 1'b1, 32'hC3AD0010, 1'b0);
        expect_rd(32'h1C000010, 1'b1);
        req(c_OP_FETCH, 32'h1C000010, 1'b1, 32'hC2AD0010, 1'b0);
        req(c_OP_FETCH, 32'h1C000014, 1'b1, 32'hC2AD0014, 1'b1);
        req(c_OP_FETCH, 32'h1C000008, 1'b1, 32'hA2, 1'b1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(),  32'd0);
        chk("reads_consumed",     rdq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
